// File: rtl/rfdc_adc_dac_router_pkg.sv
// Shared types and helpers for the RFDC ADC->DAC loopback router.
package rfdc_route_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_SYSREF, RUN} lane_state_t;

  // $clog2 that never yields zero, so single-entry ranges still get a 1-bit index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    if (n <= 32'd1) return 32'd1;
    return $unsigned($clog2(n));
  endfunction

endpackage

// File: rtl/rfdc_adc_dac_router_if.sv
// ADC (s_axis) and DAC (m_axis) stream bundle for the loopback router.
interface rfdc_adc_dac_router_if #(
  parameter int unsigned NUM_ADC = 8,
  parameter int unsigned NUM_DAC = 2,
  parameter int unsigned IN_W    = 128,
  parameter int unsigned OUT_W   = 256
);
  logic [NUM_ADC*IN_W-1:0]  s_axis_tdata;
  logic [NUM_ADC-1:0]       s_axis_tvalid;
  logic [NUM_ADC-1:0]       s_axis_tready;
  logic [NUM_DAC*OUT_W-1:0] m_axis_tdata;
  logic [NUM_DAC-1:0]       m_axis_tvalid;
  logic [NUM_DAC-1:0]       m_axis_tready;

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/rfdc_adc_dac_router_dac_pack_lane.sv
// One DAC lane: SYSREF-aligned FSM, beat packer, shadow/active select, FWFT FIFO, sticky flags.
module dac_pack_lane
  import rfdc_route_pkg::*;
#(
  parameter int unsigned NUM_ADC    = 8,
  parameter int unsigned IN_W       = 128,
  parameter int unsigned PACK       = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LANE_IDX   = 0,
  localparam int unsigned SEL_W     = clog2_min1(NUM_ADC),
  localparam int unsigned OUT_W     = IN_W * PACK
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             sysref_rise_i,
  input  logic             enable_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             sel_update_i,
  input  logic             clear_i,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic             in_valid_i,
  output logic [SEL_W-1:0] active_sel_o,
  output logic [OUT_W-1:0] m_tdata_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             aligned_o,
  output logic             overflow_o,
  output logic             realign_o
);
  localparam int unsigned PW = clog2_min1(PACK);
  localparam int unsigned AW = clog2_min1(FIFO_DEPTH);
  localparam int unsigned CW = clog2_min1(FIFO_DEPTH + 1);
  localparam logic [SEL_W-1:0] RstSel    = SEL_W'(LANE_IDX % NUM_ADC);
  localparam logic [PW-1:0]    LastPhase = PW'(PACK - 1);
  localparam logic [CW-1:0]    FullCnt   = CW'(FIFO_DEPTH);

  lane_state_t      state_q;
  logic [PW-1:0]    phase_q, phase_eff;
  logic [OUT_W-1:0] pack_q, pack_d;
  logic [SEL_W-1:0] shadow_q, active_q, sel_clamped;
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q, realign_q;
  logic             run, accept, push_req, realign_evt, pop, full, do_push, drop;

  assign sel_clamped = (32'(sel_i) >= NUM_ADC) ? SEL_W'(NUM_ADC - 1) : sel_i;

  always_comb begin
    run         = (state_q == RUN) && enable_i;
    // A SYSREF edge mid-word restarts packing so this beat lands in slot 0.
    realign_evt = run && sysref_rise_i && (phase_q != '0);
    phase_eff   = realign_evt ? '0 : phase_q;
    accept      = run && in_valid_i;
    push_req    = accept && (phase_eff == LastPhase);
    pack_d      = pack_q;
    if (accept) pack_d[phase_eff * IN_W +: IN_W] = in_data_i;
    pop         = (count_q != '0) && m_tready_i;
    full        = (count_q == FullCnt);
    do_push     = push_req && (!full || pop);
    drop        = push_req && full && !pop;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      pack_q     <= '0;
      shadow_q   <= RstSel;
      active_q   <= RstSel;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      realign_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (sel_update_i) shadow_q <= sel_clamped;
      case (state_q)
        IDLE:        if (enable_i) state_q <= WAIT_SYSREF;
        WAIT_SYSREF: begin
          if (!enable_i) begin
            state_q <= IDLE;
          end else if (sysref_rise_i) begin
            state_q  <= RUN;
            active_q <= shadow_q;
          end
        end
        RUN:         if (!enable_i) state_q <= IDLE;
        default:     state_q <= IDLE;
      endcase
      if (!run || push_req) phase_q <= '0;
      else if (accept)      phase_q <= phase_eff + 1'b1;
      else                  phase_q <= phase_eff;
      pack_q <= pack_d;
      // Select only moves on a word boundary so no DAC word mixes two ADCs.
      if (push_req) active_q <= shadow_q;
      if (do_push) begin
        mem_q[wr_ptr_q] <= pack_d;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !do_push) count_q <= count_q - 1'b1;
      overflow_q <= drop        | (overflow_q & ~clear_i);
      realign_q  <= realign_evt | (realign_q & ~clear_i);
    end
  end

  assign active_sel_o = active_q;
  assign m_tdata_o    = mem_q[rd_ptr_q];
  assign m_tvalid_o   = (count_q != '0);
  assign aligned_o    = (state_q == RUN);
  assign overflow_o   = overflow_q;
  assign realign_o    = realign_q;

endmodule

// File: rtl/rfdc_adc_dac_router.sv
// ADC->DAC loopback router: shared SYSREF edge detect, per-lane ADC mux, NUM_DAC packing lanes.
module rfdc_adc_dac_router
  import rfdc_route_pkg::*;
#(
  parameter int unsigned NUM_ADC    = 8,
  parameter int unsigned NUM_DAC    = 2,
  parameter int unsigned IN_W       = 128,
  parameter int unsigned PACK       = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned SEL_W     = clog2_min1(NUM_ADC),
  localparam int unsigned OUT_W     = IN_W * PACK
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     sysref_i,
  input  logic [NUM_DAC-1:0]       enable_i,
  input  logic [NUM_DAC*SEL_W-1:0] sel_i,
  input  logic                     sel_update_i,
  input  logic                     clear_i,
  rfdc_adc_dac_router_if.slave     axis,
  output logic [NUM_DAC-1:0]       aligned_o,
  output logic [NUM_DAC-1:0]       overflow_o,
  output logic [NUM_DAC-1:0]       realign_o
);
  logic                            sysref_q, sysref_rise;
  logic [NUM_DAC-1:0][OUT_W-1:0]   m_data;
  logic [NUM_DAC-1:0]              m_valid;

  always_ff @(posedge aclk) begin
    if (areset) sysref_q <= 1'b0;
    else        sysref_q <= sysref_i;
  end

  assign sysref_rise        = sysref_i & ~sysref_q;
  // The RFDC ADC cannot be stalled.
  assign axis.s_axis_tready = '1;
  assign axis.m_axis_tdata  = m_data;
  assign axis.m_axis_tvalid = m_valid;

  for (genvar g = 0; g < NUM_DAC; g++) begin : g_lane
    logic [SEL_W-1:0] act;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;

    assign in_data  = axis.s_axis_tdata[act * IN_W +: IN_W];
    assign in_valid = axis.s_axis_tvalid[act];

    dac_pack_lane #(
      .NUM_ADC   (NUM_ADC),
      .IN_W      (IN_W),
      .PACK      (PACK),
      .FIFO_DEPTH(FIFO_DEPTH),
      .LANE_IDX  (g)
    ) u_lane (
      .aclk         (aclk),
      .areset       (areset),
      .sysref_rise_i(sysref_rise),
      .enable_i     (enable_i[g]),
      .sel_i        (sel_i[g*SEL_W +: SEL_W]),
      .sel_update_i (sel_update_i),
      .clear_i      (clear_i),
      .in_data_i    (in_data),
      .in_valid_i   (in_valid),
      .active_sel_o (act),
      .m_tdata_o    (m_data[g]),
      .m_tvalid_o   (m_valid[g]),
      .m_tready_i   (axis.m_axis_tready[g]),
      .aligned_o    (aligned_o[g]),
      .overflow_o   (overflow_o[g]),
      .realign_o    (realign_o[g])
    );
  end

endmodule

// File: tb/tb_rfdc_adc_dac_router.sv
// Bench for rfdc_adc_dac_router: directed scenarios plus random traffic against a queue model.
module tb_rfdc_adc_dac_router;
  // Six ADCs leave select codes 6 and 7 out of range, so clamping is exercised.
  localparam int unsigned NA = 6;
  localparam int unsigned ND = 2;
  localparam int unsigned IW = 128;
  localparam int unsigned PK = 2;
  localparam int unsigned FD = 4;
  localparam int unsigned SW = 3;
  localparam int unsigned OW = IW * PK;
  localparam int MIdle = 0, MWait = 1, MRun = 2;

  logic            aclk;
  logic            areset, sysref_i, sel_update_i, clear_i;
  logic [ND-1:0]   enable_i, aligned_o, overflow_o, realign_o;
  logic [ND*SW-1:0] sel_i;

  rfdc_adc_dac_router_if #(.NUM_ADC(NA), .NUM_DAC(ND), .IN_W(IW), .OUT_W(OW)) bus ();

  rfdc_adc_dac_router #(
    .NUM_ADC(NA), .NUM_DAC(ND), .IN_W(IW), .PACK(PK), .FIFO_DEPTH(FD)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .sysref_i    (sysref_i),
    .enable_i    (enable_i),
    .sel_i       (sel_i),
    .sel_update_i(sel_update_i),
    .clear_i     (clear_i),
    .axis        (bus),
    .aligned_o   (aligned_o),
    .overflow_o  (overflow_o),
    .realign_o   (realign_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Behavioural model: lane mode, collected beats, expected output words, flags.
  int            mode_m [ND];
  int            shadow_m [ND];
  int            active_m [ND];
  logic [IW-1:0] beats_m [ND][$];
  logic [OW-1:0] fifo_m [ND][$];
  bit            ovf_m [ND];
  bit            rea_m [ND];
  bit            sr_prev_m;
  bit            chk_en;
  int            n_checks, n_fail;

  function automatic logic [IW-1:0] beat(input int k, input int j);
    return {32'(k), 32'(j), 64'h0123_4567_89AB_CDEF};
  endfunction

  task automatic chk(input string name, input int lane, input logic [OW-1:0] got,
                     input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d @%0t: got %h expected %h", name, lane, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < ND; l++) begin
      mode_m[l]   = MIdle;
      shadow_m[l] = l % NA;
      active_m[l] = l % NA;
      beats_m[l].delete();
      fifo_m[l].delete();
      ovf_m[l] = 0;
      rea_m[l] = 0;
    end
    sr_prev_m = 0;
  endtask

  task automatic model_step();
    bit sr;
    if (areset) begin
      model_reset();
      chk_en = 1;
      return;
    end
    sr = sysref_i && !sr_prev_m;
    sr_prev_m = sysref_i;
    for (int l = 0; l < ND; l++) begin
      bit            push, set_o, set_r;
      logic [OW-1:0] word;
      int            a, s;
      push = 0; set_o = 0; set_r = 0; word = '0;
      if (!enable_i[l]) begin
        mode_m[l] = MIdle;
        beats_m[l].delete();
      end else if (mode_m[l] == MIdle) begin
        mode_m[l] = MWait;
      end else if (mode_m[l] == MWait) begin
        if (sr) begin
          mode_m[l] = MRun;
          beats_m[l].delete();
          active_m[l] = shadow_m[l];
        end
      end else begin
        if (sr && beats_m[l].size() != 0) begin
          beats_m[l].delete();
          set_r = 1;
        end
        a = active_m[l];
        if (bus.s_axis_tvalid[a]) begin
          beats_m[l].push_back(bus.s_axis_tdata[a*IW +: IW]);
          if (beats_m[l].size() == PK) begin
            for (int i = 0; i < PK; i++) word[i*IW +: IW] = beats_m[l][i];
            push = 1;
            beats_m[l].delete();
            active_m[l] = shadow_m[l];
          end
        end
      end
      if (fifo_m[l].size() != 0 && bus.m_axis_tready[l]) void'(fifo_m[l].pop_front());
      if (push) begin
        if (fifo_m[l].size() < FD) fifo_m[l].push_back(word);
        else set_o = 1;
      end
      ovf_m[l] = set_o ? 1'b1 : (clear_i ? 1'b0 : ovf_m[l]);
      rea_m[l] = set_r ? 1'b1 : (clear_i ? 1'b0 : rea_m[l]);
      if (sel_update_i) begin
        s = int'(sel_i[l*SW +: SW]);
        shadow_m[l] = (s >= NA) ? NA - 1 : s;
      end
    end
  endtask

  task automatic compare();
    chk("s_tready", 0, OW'(bus.s_axis_tready), OW'({NA{1'b1}}));
    for (int l = 0; l < ND; l++) begin
      bit ev;
      ev = fifo_m[l].size() != 0;
      chk("tvalid", l, OW'(bus.m_axis_tvalid[l]), OW'(ev));
      if (ev) chk("tdata", l, bus.m_axis_tdata[l*OW +: OW], fifo_m[l][0]);
      chk("aligned", l, OW'(aligned_o[l]), OW'(mode_m[l] == MRun));
      chk("overflow", l, OW'(overflow_o[l]), OW'(ovf_m[l]));
      chk("realign", l, OW'(realign_o[l]), OW'(rea_m[l]));
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_all(input int j);
    for (int k = 0; k < NA; k++) bus.s_axis_tdata[k*IW +: IW] = beat(k, j);
    bus.s_axis_tvalid = '1;
  endtask

  task automatic idle_in();
    bus.s_axis_tvalid = '0;
  endtask

  function automatic logic [OW-1:0] word_of(input int k, input int j0);
    return {beat(k, j0 + 1), beat(k, j0)};
  endfunction

  function automatic logic [OW-1:0] lane_data(input int l);
    return bus.m_axis_tdata[l*OW +: OW];
  endfunction

  initial begin
    int drained;
    areset = 1'b1; sysref_i = 1'b0; enable_i = '0; sel_i = '0;
    sel_update_i = 1'b0; clear_i = 1'b0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = '0; bus.m_axis_tready = '0;
    n_checks = 0; n_fail = 0; chk_en = 0;
    model_reset();
    fork
      forever begin @(posedge aclk); model_step(); end
      forever begin @(negedge aclk); if (chk_en) compare(); end
    join_none

    tick(); tick(); tick();
    chk("rst_tvalid", 0, OW'(bus.m_axis_tvalid), OW'(0));
    chk("rst_tdata", 0, lane_data(0), OW'(0));
    chk("rst_tready", 0, OW'(bus.s_axis_tready), OW'(6'h3f));
    areset = 1'b0;

    // 1: beats before SYSREF are ignored; afterwards {B,A}, {D,C}.
    enable_i = 2'b01;
    for (int j = 0; j < 4; j++) begin drive_all(j); tick(); end
    chk("pre_sysref_quiet", 0, OW'(bus.m_axis_tvalid[0]), OW'(0));
    idle_in(); sysref_i = 1'b1; tick();
    drive_all(0); tick();
    chk("one_beat_no_word", 0, OW'(bus.m_axis_tvalid[0]), OW'(0));
    drive_all(1); tick();
    chk("word_ba_valid", 0, OW'(bus.m_axis_tvalid[0]), OW'(1));
    chk("word_ba", 0, lane_data(0), word_of(0, 0));
    drive_all(2); tick(); drive_all(3); tick();
    chk("word_ba_held", 0, lane_data(0), word_of(0, 0));
    idle_in(); bus.m_axis_tready = 2'b01; tick();
    chk("word_dc", 0, lane_data(0), word_of(0, 2));
    tick();
    chk("drained", 0, OW'(bus.m_axis_tvalid[0]), OW'(0));

    // 2: SYSREF edge at phase 1 drops the partial word.
    sysref_i = 1'b0; tick();
    drive_all(10); tick();
    sysref_i = 1'b1; drive_all(11); tick();
    chk("realign_set", 0, OW'(realign_o[0]), OW'(1));
    drive_all(12); tick();
    chk("realigned_word", 0, lane_data(0), word_of(0, 11));
    idle_in(); clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("realign_clear", 0, OW'(realign_o[0]), OW'(0));

    // 3: select change mid-word on lane1 takes effect on the next word.
    enable_i = 2'b11; sysref_i = 1'b0; tick();
    sysref_i = 1'b1; tick();
    sel_i = {3'd5, 3'd0}; sel_update_i = 1'b1; drive_all(20); tick();
    sel_update_i = 1'b0;
    for (int j = 21; j < 24; j++) begin drive_all(j); tick(); end
    idle_in();
    chk("sel_old_word", 1, lane_data(1), word_of(1, 20));
    bus.m_axis_tready = 2'b11; tick();
    chk("sel_new_word", 1, lane_data(1), word_of(5, 22));
    bus.m_axis_tready = 2'b01; tick();

    // 4: six words into a four-deep FIFO.
    bus.m_axis_tready = 2'b00;
    for (int j = 30; j < 42; j++) begin drive_all(j); tick(); end
    idle_in();
    chk("overflow_set", 0, OW'(overflow_o[0]), OW'(1));
    bus.m_axis_tready = 2'b11; drained = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.m_axis_tvalid[0]) drained++;
      tick();
    end
    chk("drain_count", 0, OW'(drained), OW'(4));
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("overflow_clear", 0, OW'(overflow_o[0]), OW'(0));

    // 5: full FIFO with simultaneous pop and push.
    bus.m_axis_tready = 2'b00;
    for (int j = 50; j < 59; j++) begin drive_all(j); tick(); end
    drive_all(59); bus.m_axis_tready = 2'b01; tick();
    idle_in(); bus.m_axis_tready = 2'b00;
    chk("full_pushpop_no_ovf", 0, OW'(overflow_o[0]), OW'(0));
    chk("full_pushpop_head", 0, lane_data(0), word_of(0, 52));
    bus.m_axis_tready = 2'b11;
    for (int i = 0; i < 6; i++) tick();

    // 6: reset mid-RUN with queued data.
    bus.m_axis_tready = 2'b00;
    for (int j = 60; j < 64; j++) begin drive_all(j); tick(); end
    idle_in(); areset = 1'b1; tick();
    chk("mid_rst_tvalid", 0, OW'(bus.m_axis_tvalid), OW'(0));
    chk("mid_rst_aligned", 0, OW'(aligned_o), OW'(0));
    chk("mid_rst_flags", 0, OW'({overflow_o, realign_o}), OW'(0));
    chk("mid_rst_tready", 0, OW'(bus.s_axis_tready), OW'(6'h3f));
    areset = 1'b0;

    // Random traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      int idx;
      idx = int'($urandom_range(ND - 1));
      if ($urandom_range(99) < 3) enable_i[idx] = ~enable_i[idx];
      if ($urandom_range(99) < 4) sysref_i = ~sysref_i;
      sel_update_i = ($urandom_range(99) < 5);
      if (sel_update_i) sel_i = ND*SW'($urandom);
      clear_i = ($urandom_range(99) < 3);
      areset = (c == 1500);
      for (int k = 0; k < NA; k++) begin
        bus.s_axis_tdata[k*IW +: IW] = {$urandom, $urandom, $urandom, $urandom};
        bus.s_axis_tvalid[k] = ($urandom_range(99) < 80);
      end
      for (int l = 0; l < ND; l++) bus.m_axis_tready[l] = ($urandom_range(99) < 60);
      tick();
    end
    areset = 1'b0; idle_in(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
